// File: rtl/snake_draw_scheduler.sv
// Draw scheduler: arbitrates clear/tail/head/apple requests into a pixel raster.
// Optional DRAW_SCHED_AUTO_CLEAR_EN: reset arms a full-screen clear.
module snake_draw_scheduler #(
    parameter int          BLOCK_SIZE   = 10,
    parameter int          SCREEN_W     = 240,
    parameter int          SCREEN_H     = 320,
    parameter logic [15:0] BG_COLOUR    = 16'h0000,
    parameter logic [15:0] SNAKE_COLOUR = 16'h07E0,
    parameter logic [15:0] APPLE_COLOUR = 16'hF800
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clearReq,
    input  logic        tailReq,
    input  logic [7:0]  tailX,
    input  logic [8:0]  tailY,
    input  logic        headReq,
    input  logic [7:0]  headX,
    input  logic [8:0]  headY,
    input  logic        appleReq,
    input  logic [7:0]  appleX,
    input  logic [8:0]  appleY,
    output logic [7:0]  pixelX,
    output logic [8:0]  pixelY,
    output logic [15:0] pixelData,
    output logic        pixelWrite,
    input  logic        pixelReady,
    output logic        busy,
    output logic        cmdDone,
    output logic [1:0]  cmdId
);

    localparam logic [9:0] BLK_M1 = 10'(BLOCK_SIZE - 1);
    localparam logic [9:0] W_M1   = 10'(SCREEN_W - 1);
    localparam logic [9:0] H_M1   = 10'(SCREEN_H - 1);
    localparam logic [9:0] W_LIM  = 10'(SCREEN_W);
    localparam logic [9:0] H_LIM  = 10'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  pend;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [7:0]  tail_x;
    logic [7:0]  head_x;
    logic [7:0]  apple_x;
    logic [8:0]  tail_y;
    logic [8:0]  head_y;
    logic [8:0]  apple_y;

    logic [1:0]  sel_id;
    logic [7:0]  sel_x;
    logic [8:0]  sel_y;
    logic [15:0] sel_colour;
    logic [9:0]  x_end_sel;
    logic [9:0]  y_end_sel;
    logic        sel_empty;

    logic [7:0]  x_org;
    logic [9:0]  x_end;
    logic [9:0]  y_end;
    logic [1:0]  act_id;

    assign req  = {appleReq, headReq, tailReq, clearReq};
    assign busy = ~reset & ((state != IDLE) | (|pend));

    // Winner is only granted while idle, so a running fill is never pre-empted.
    always_comb begin
        grant      = 4'b0000;
        sel_id     = 2'd0;
        sel_x      = 8'd0;
        sel_y      = 9'd0;
        sel_colour = BG_COLOUR;
        if (state == IDLE) begin
            priority case (1'b1)
                pend[0]: begin
                    grant = 4'b0001;
                end
                pend[1]: begin
                    grant  = 4'b0010;
                    sel_id = 2'd1;
                    sel_x  = tail_x;
                    sel_y  = tail_y;
                end
                pend[2]: begin
                    grant      = 4'b0100;
                    sel_id     = 2'd2;
                    sel_x      = head_x;
                    sel_y      = head_y;
                    sel_colour = SNAKE_COLOUR;
                end
                pend[3]: begin
                    grant      = 4'b1000;
                    sel_id     = 2'd3;
                    sel_x      = apple_x;
                    sel_y      = apple_y;
                    sel_colour = APPLE_COLOUR;
                end
                default: ;
            endcase
        end
    end

    // End coordinates in 10 bits so origin + size never wraps before clipping.
    always_comb begin
        x_end_sel = {2'b00, sel_x} + BLK_M1;
        y_end_sel = {1'b0, sel_y} + BLK_M1;
        if (x_end_sel > W_M1) begin
            x_end_sel = W_M1;
        end
        if (y_end_sel > H_M1) begin
            y_end_sel = H_M1;
        end
        if (grant[0]) begin
            x_end_sel = W_M1;
            y_end_sel = H_M1;
        end
        sel_empty = ({2'b00, sel_x} >= W_LIM) ||
                    ({1'b0, sel_y} >= H_LIM);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
`ifdef DRAW_SCHED_AUTO_CLEAR_EN
            pend <= 4'b0001;
`else
            pend <= 4'b0000;
`endif
            tail_x  <= 8'd0;
            tail_y  <= 9'd0;
            head_x  <= 8'd0;
            head_y  <= 9'd0;
            apple_x <= 8'd0;
            apple_y <= 9'd0;
        end else begin
            pend <= (pend & ~grant) | req;
            if (tailReq) begin
                tail_x <= tailX;
                tail_y <= tailY;
            end
            if (headReq) begin
                head_x <= headX;
                head_y <= headY;
            end
            if (appleReq) begin
                apple_x <= appleX;
                apple_y <= appleY;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pixelX     <= 8'd0;
            pixelY     <= 9'd0;
            pixelData  <= 16'd0;
            pixelWrite <= 1'b0;
            cmdDone    <= 1'b0;
            cmdId      <= 2'd0;
            x_org      <= 8'd0;
            x_end      <= 10'd0;
            y_end      <= 10'd0;
            act_id     <= 2'd0;
        end else begin
            cmdDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        x_org     <= sel_x;
                        x_end     <= x_end_sel;
                        y_end     <= y_end_sel;
                        act_id    <= sel_id;
                        pixelX    <= sel_x;
                        pixelY    <= sel_y;
                        pixelData <= sel_colour;
                        if (sel_empty) begin
                            state   <= DONE;
                            cmdDone <= 1'b1;
                            cmdId   <= sel_id;
                        end else begin
                            state      <= FILL;
                            pixelWrite <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (pixelReady) begin
                        if ({2'b00, pixelX} == x_end) begin
                            if ({1'b0, pixelY} == y_end) begin
                                state      <= DONE;
                                pixelWrite <= 1'b0;
                                cmdDone    <= 1'b1;
                                cmdId      <= act_id;
                            end else begin
                                pixelX <= x_org;
                                pixelY <= pixelY + 9'd1;
                            end
                        end else begin
                            pixelX <= pixelX + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_draw_scheduler.sv
// Bench for snake_draw_scheduler: vector table, corner sequences, random traffic.
// Expected rasters come from a block-area model, not from the RTL structure.
module tb_snake_draw_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        clearReq, tailReq, headReq, appleReq;
    logic [7:0]  tailX, headX, appleX;
    logic [8:0]  tailY, headY, appleY;
    logic [7:0]  pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic        busy;
    logic        cmdDone;
    logic [1:0]  cmdId;

    int nerr = 0;
    int nchk = 0;
    int ready_mode = 0;
    int n_stall = 0;

    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } pix_t;

    typedef struct {
        int          id;
        int          x;
        int          y;
        int          n;
        int          lx;
        int          ly;
        logic [15:0] d;
    } vec_t;

    pix_t wr_q[$];
    pix_t exp_q[$];
    int   done_q[$];
    logic stall_prev = 1'b0;
    pix_t held;

    always #5 clock = ~clock;

    snake_draw_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .clearReq   (clearReq),
        .tailReq    (tailReq),
        .tailX      (tailX),
        .tailY      (tailY),
        .headReq    (headReq),
        .headX      (headX),
        .headY      (headY),
        .appleReq   (appleReq),
        .appleX     (appleX),
        .appleY     (appleY),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .pixelData  (pixelData),
        .pixelWrite (pixelWrite),
        .pixelReady (pixelReady),
        .busy       (busy),
        .cmdDone    (cmdDone),
        .cmdId      (cmdId)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: record handshakes and completions, check stalled outputs hold.
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_stall++;
                chk("stall hold", {pixelWrite, pixelX, pixelY, pixelData},
                    {1'b1, held});
            end
            if (pixelWrite && pixelReady) begin
                wr_q.push_back('{x: pixelX, y: pixelY, d: pixelData});
            end
            if (cmdDone) begin
                done_q.push_back(int'(cmdId));
            end
            stall_prev = pixelWrite && !pixelReady;
            held = '{x: pixelX, y: pixelY, d: pixelData};
        end
    end

    initial begin
        pixelReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: pixelReady = 1'b1;
                1: pixelReady = ~pixelReady;
                default: pixelReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clr_sb();
        wr_q.delete();
        exp_q.delete();
        done_q.delete();
    endtask

    function automatic logic [15:0] colour_of(input int id);
        return (id == 2) ? 16'h07E0 : (id == 3) ? 16'hF800 : 16'h0000;
    endfunction

    // Reference: a command paints the clipped w x h rectangle row by row.
    task automatic model_cmd(input int id, input int ox, input int oy);
        int w;
        int h;
        if (id == 0) begin
            ox = 0;
            oy = 0;
            w  = 240;
            h  = 320;
        end else begin
            w = (ox >= 240) ? 0 : ((240 - ox < 10) ? 240 - ox : 10);
            h = (oy >= 320) ? 0 : ((320 - oy < 10) ? 320 - oy : 10);
        end
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                exp_q.push_back('{x: 8'(ox + i), y: 9'(oy + j),
                                  d: colour_of(id)});
            end
        end
    endtask

    task automatic drive_req(input logic [3:0] m,
                             input int tx, input int ty,
                             input int hx, input int hy,
                             input int ax, input int ay);
        clearReq = m[0];
        tailReq  = m[1];
        headReq  = m[2];
        appleReq = m[3];
        tailX    = 8'(tx);
        tailY    = 9'(ty);
        headX    = 8'(hx);
        headY    = 9'(hy);
        appleX   = 8'(ax);
        appleY   = 9'(ay);
        tick();
        clearReq = 1'b0;
        tailReq  = 1'b0;
        headReq  = 1'b0;
        appleReq = 1'b0;
    endtask

    task automatic wait_done(input int n, input int lim, input string nm);
        int c;
        c = 0;
        while (done_q.size() < n && c < lim) begin
            step();
            c++;
        end
        chk({nm, " done count"}, done_q.size(), n);
    endtask

    task automatic cmp_writes(input string nm);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        chk({nm, " writes"}, wr_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i >= wr_q.size() || wr_q[i] != exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (bad != 0) $display("  %s first pixel diff at %0d", nm, first);
        chk({nm, " pixels"}, bad, 0);
    endtask

    function automatic logic [63:0] done_seq();
        logic [63:0] s;
        s = 64'd0;
        foreach (done_q[i]) s = (s << 4) | 64'(done_q[i]);
        return s;
    endfunction

    vec_t        vt[10];
    vec_t        v;
    int          rx[4];
    int          ry[4];
    logic [3:0]  m;
    logic [63:0] es;
    int          nexp;
    int          dup;
    int          c;
    bit          seen[int];

    initial begin
        vt[0] = '{2, 40, 30, 100, 49, 39, 16'h07E0};
        vt[1] = '{1, 30, 30, 100, 39, 39, 16'h0000};
        vt[2] = '{3, 235, 315, 25, 239, 319, 16'hF800};
        vt[3] = '{3, 240, 0, 0, 0, 0, 16'hF800};
        vt[4] = '{2, 0, 0, 100, 9, 9, 16'h07E0};
        vt[5] = '{1, 0, 315, 50, 9, 319, 16'h0000};
        vt[6] = '{2, 239, 0, 10, 239, 9, 16'h07E0};
        vt[7] = '{3, 0, 320, 0, 0, 0, 16'hF800};
        vt[8] = '{3, 255, 511, 0, 0, 0, 16'hF800};
        vt[9] = '{3, 100, 200, 100, 109, 209, 16'hF800};

        reset    = 1'b1;
        clearReq = 1'b0;
        tailReq  = 1'b0;
        headReq  = 1'b0;
        appleReq = 1'b0;
        tailX    = 8'd0;
        tailY    = 9'd0;
        headX    = 8'd0;
        headY    = 9'd0;
        appleX   = 8'd0;
        appleY   = 9'd0;
        repeat (3) tick();
        chk("rst pixelX", pixelX, 0);
        chk("rst pixelY", pixelY, 0);
        chk("rst pixelData", pixelData, 0);
        chk("rst pixelWrite", pixelWrite, 0);
        chk("rst busy", busy, 0);
        chk("rst cmdDone", cmdDone, 0);
        chk("rst cmdId", cmdId, 0);
        clr_sb();
        reset = 1'b0;

`ifdef DRAW_SCHED_AUTO_CLEAR_EN
        step();
        chk("autoclear busy", busy, 1);
        model_cmd(0, 0, 0);
        wait_done(1, 80000, "autoclear");
        chk("autoclear id", done_seq(), 64'h0);
        cmp_writes("autoclear");
        step();
`endif

        foreach (vt[i]) begin
            v = vt[i];
            clr_sb();
            model_cmd(v.id, v.x, v.y);
            drive_req(4'(1 << v.id), v.x, v.y, v.x, v.y, v.x, v.y);
            step();
            chk($sformatf("vec%0d write N+1", i), pixelWrite, 0);
            step();
            chk($sformatf("vec%0d write N+2", i), pixelWrite, v.n != 0);
            if (v.n != 0) begin
                chk($sformatf("vec%0d first pixel", i),
                    {pixelX, pixelY, pixelData},
                    {8'(v.x), 9'(v.y), v.d});
            end
            wait_done(1, 500, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d cmdId", i), done_seq(), 64'(v.id));
            chk($sformatf("vec%0d count", i), wr_q.size(), v.n);
            if (v.n != 0 && wr_q.size() != 0) begin
                chk($sformatf("vec%0d last pixel", i),
                    {wr_q[$].x, wr_q[$].y}, {8'(v.lx), 9'(v.ly)});
            end
            cmp_writes($sformatf("vec%0d", i));
            step();
            chk($sformatf("vec%0d cmdDone width", i), cmdDone, 0);
            chk($sformatf("vec%0d busy after", i), busy, 0);
        end

        clr_sb();
        model_cmd(1, 30, 30);
        model_cmd(2, 60, 30);
        model_cmd(3, 120, 160);
        drive_req(4'b1110, 30, 30, 60, 30, 120, 160);
        wait_done(3, 1000, "prio");
        chk("prio order", done_seq(), 64'h123);
        cmp_writes("prio");
        step();

        clr_sb();
        model_cmd(2, 50, 50);
        model_cmd(2, 70, 70);
        drive_req(4'b0100, 0, 0, 50, 50, 0, 0);
        drive_req(4'b0100, 0, 0, 70, 70, 0, 0);
        wait_done(2, 1000, "rearm");
        chk("rearm order", done_seq(), 64'h22);
        cmp_writes("rearm");
        step();

        ready_mode = 1;
        n_stall    = 0;
        clr_sb();
        model_cmd(2, 0, 0);
        drive_req(4'b0100, 0, 0, 0, 0, 0, 0);
        wait_done(1, 1000, "bp");
        cmp_writes("bp");
        dup = 0;
        seen.delete();
        foreach (wr_q[i]) begin
            if (seen.exists(int'(wr_q[i].x) * 512 + int'(wr_q[i].y))) dup++;
            seen[int'(wr_q[i].x) * 512 + int'(wr_q[i].y)] = 1'b1;
        end
        chk("bp duplicates", dup, 0);
        chk("bp stalls seen", n_stall > 0, 1);

        ready_mode = 2;
        for (int it = 0; it < 12; it++) begin
            step();
            clr_sb();
            m    = 4'($urandom_range(1, 7) << 1);
            es   = 64'd0;
            nexp = 0;
            for (int r = 1; r <= 3; r++) begin
                rx[r] = $urandom_range(0, 255);
                ry[r] = ($urandom_range(0, 7) == 0) ?
                        $urandom_range(320, 511) : $urandom_range(0, 319);
                if (m[r]) begin
                    model_cmd(r, rx[r], ry[r]);
                    es = (es << 4) | 64'(r);
                    nexp++;
                end
            end
            drive_req(m, rx[1], ry[1], rx[2], ry[2], rx[3], ry[3]);
            wait_done(nexp, 3000, $sformatf("rand%0d", it));
            chk($sformatf("rand%0d order", it), done_seq(), es);
            cmp_writes($sformatf("rand%0d", it));
        end
        ready_mode = 0;
        step();
        step();

`ifndef DRAW_SCHED_AUTO_CLEAR_EN
        clr_sb();
        model_cmd(0, 0, 0);
        model_cmd(2, 20, 20);
        drive_req(4'b0001, 0, 0, 0, 0, 0, 0);
        repeat (100) tick();
        drive_req(4'b0100, 0, 0, 10, 10, 0, 0);
        repeat (100) tick();
        drive_req(4'b0100, 0, 0, 20, 20, 0, 0);
        wait_done(2, 80000, "clear");
        chk("clear order", done_seq(), 64'h02);
        cmp_writes("clear");
        step();
`endif

        clr_sb();
        drive_req(4'b0100, 0, 0, 100, 100, 0, 0);
        c = 0;
        while (wr_q.size() < 50 && c < 500) begin
            step();
            c++;
        end
        chk("midfill reached", wr_q.size() >= 50, 1);
        reset = 1'b1;
        #1;
        chk("midfill pixelWrite", pixelWrite, 0);
        chk("midfill busy", busy, 0);
        chk("midfill cmdDone", cmdDone, 0);
        tick();
        tick();
        reset = 1'b0;
`ifdef DRAW_SCHED_AUTO_CLEAR_EN
        step();
        chk("post-rst busy", busy, 1);
        chk("post-rst idle write", pixelWrite, 0);
        step();
        chk("post-rst clear write", pixelWrite, 1);
        chk("post-rst clear origin", {pixelX, pixelY, pixelData}, 33'd0);
`else
        step();
        chk("post-rst busy", busy, 0);
        step();
        chk("post-rst write", pixelWrite, 0);
        chk("post-rst busy later", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
